// File: rtl/multi_write_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : multi_write_fifo
//  Purpose  : Result FIFO merging NUM_ENGINES write ports (lowest index first)
//             into one show-ahead read stream, with sticky error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_write_fifo #(
    parameter int DATA_WIDTH  = 21,
    parameter int DEPTH       = 16,
    parameter int NUM_ENGINES = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_ENGINES*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_ENGINES-1:0]            write_en,
    output logic [NUM_ENGINES-1:0]            write_ready,
    input  logic                              read_en,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              empty,
    output logic                              full,
    output logic                              almost_full,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_THRESH = CNT_W'(DEPTH - NUM_ENGINES);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     write_ptr;
    logic [ADDR_W-1:0]     read_ptr;
    logic [CNT_W-1:0]      free;
    logic [CNT_W-1:0]      requested;
    logic [CNT_W-1:0]      accepted;
    logic [CNT_W-1:0]      ahead [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] accept;
    logic [NUM_ENGINES-1:0] refused;
    logic                  do_read;

    // Readiness counts lower-index *requests*, so an accepted engine always
    // has every lower requester accepted too; its slot offset is ahead[i].
    always_comb begin
        free      = DEPTH_C - count;
        requested = '0;
        accepted  = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            ahead[i]       = requested;
            write_ready[i] = (free > requested);
            accept[i]      = write_en[i] && write_ready[i];
            refused[i]     = write_en[i] && !write_ready[i];
            if (write_en[i]) begin
                requested = requested + CNT_W'(1);
            end
            if (accept[i]) begin
                accepted = accepted + CNT_W'(1);
            end
        end
    end

    assign do_read     = read_en && !empty;
    assign data_out    = mem[read_ptr];
    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count > AF_THRESH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (accept[i]) begin
                    mem[write_ptr + ADDR_W'(ahead[i])] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            write_ptr <= write_ptr + ADDR_W'(accepted);
            if (do_read) begin
                read_ptr <= read_ptr + ADDR_W'(1);
            end
            count     <= count + accepted - CNT_W'(do_read);
            overflow  <= overflow | (|refused);
            underflow <= underflow | (read_en && empty);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_write_fifo.sv
`default_nettype none
// Testbench for multi_write_fifo: scenario tasks with a queue scoreboard.
module tb_multi_write_fifo;

    localparam int DW = 21;
    localparam int D  = 16;
    localparam int NE = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NE*DW-1:0] data_in = '0;
    logic [NE-1:0]   write_en = '0;
    logic [NE-1:0]   write_ready;
    logic            read_en = 1'b0;
    logic [DW-1:0]   data_out;
    logic            empty, full, almost_full;
    logic [4:0]      count;
    logic            overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;
    int mcount   = 0;
    logic [DW-1:0] sb [$];

    multi_write_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .NUM_ENGINES(NE)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .write_en(write_en),
        .write_ready(write_ready), .read_en(read_en), .data_out(data_out),
        .empty(empty), .full(full), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [NE-1:0] ready_model(input logic [NE-1:0] we, input int cnt);
        logic [NE-1:0] r;
        int ahead;
        ahead = 0;
        for (int i = 0; i < NE; i++) begin
            r[i] = ((D - cnt) > ahead);
            if (we[i]) ahead++;
        end
        return r;
    endfunction

    task automatic apply(input logic [NE-1:0] we, input logic [NE*DW-1:0] d, input logic re);
        write_en = we;
        data_in  = d;
        read_en  = re;
        #1;
    endtask

    // Update the scoreboard from the inputs currently driven, then clock.
    task automatic tick();
        logic [NE-1:0] rdy;
        int k;
        rdy = ready_model(write_en, mcount);
        k = 0;
        if (reset) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (read_en && mcount > 0) begin
                void'(sb.pop_front());
                mcount--;
            end
            for (int i = 0; i < NE; i++) begin
                if (write_en[i] && rdy[i]) begin
                    sb.push_back(data_in[i*DW +: DW]);
                    k++;
                end
            end
            mcount += k;
        end
        @(posedge clk);
        #1;
        write_en = '0;
        read_en  = 1'b0;
    endtask

    function automatic logic [NE*DW-1:0] pack4(input int a, input int b, input int c, input int e);
        return {DW'(e), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_flags: empty=%b full=%b af=%b count=%0d want 1 0 0 0", empty, full, almost_full, count);
        end
        n_checks++;
        if (write_ready !== 4'b1111 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: ready=%b ovf=%b unf=%b want 1111 0 0", write_ready, overflow, underflow);
        end
    endtask

    task automatic test_drain(input string tag);
        int guard;
        guard = 0;
        while (mcount > 0 && guard < 64) begin
            apply('0, '0, 1'b1);
            n_checks++;
            if (data_out !== sb[0]) begin
                n_fail++;
                $display("FAIL %s_order: got 0x%0h want 0x%0h", tag, data_out, sb[0]);
            end
            tick();
            guard++;
        end
        n_checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL %s_empty: empty=%b count=%0d want 1 0", tag, empty, count);
        end
    endtask

    task automatic test_burst();
        apply(4'b1111, pack4('h10, 'h11, 'h12, 'h13), 1'b0);
        tick();
        n_checks++;
        if (count !== 5'd4 || empty !== 1'b0 || almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_count: count=%0d empty=%b af=%b want 4 0 0", count, empty, almost_full);
        end
        n_checks++;
        if (data_out !== 21'h10) begin
            n_fail++;
            $display("FAIL burst_head: got 0x%0h want 0x10", data_out);
        end
        test_drain("burst");
    endtask

    task automatic test_partial();
        for (int c = 0; c < 3; c++) begin
            apply(4'b1111, pack4('h20 + 4*c, 'h21 + 4*c, 'h22 + 4*c, 'h23 + 4*c), 1'b0);
            tick();
        end
        apply(4'b0011, pack4('h2c, 'h2d, 0, 0), 1'b0);
        tick();
        n_checks++;
        if (count !== 5'd14 || almost_full !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_fill: count=%0d af=%b full=%b want 14 1 0", count, almost_full, full);
        end
        apply(4'b1011, pack4('h30, 'h31, 'h32, 'h33), 1'b0);
        n_checks++;
        if (write_ready !== 4'b0011) begin
            n_fail++;
            $display("FAIL partial_ready: got %b want 0011", write_ready);
        end
        tick();
        n_checks++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_full: count=%0d full=%b ovf=%b want 16 1 1", count, full, overflow);
        end
    endtask

    task automatic test_full_read_write();
        apply(4'b0001, pack4('h40, 0, 0, 0), 1'b1);
        n_checks++;
        if (write_ready !== 4'b0000 || data_out !== sb[0]) begin
            n_fail++;
            $display("FAIL fullrw_ready: ready=%b head=0x%0h want 0000 0x%0h", write_ready, data_out, sb[0]);
        end
        tick();
        n_checks++;
        if (count !== 5'd15 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL fullrw_count: count=%0d full=%b want 15 0", count, full);
        end
        apply(4'b0001, pack4('h40, 0, 0, 0), 1'b0);
        n_checks++;
        if (write_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL fullrw_retry_ready: got %b want 1", write_ready[0]);
        end
        tick();
        n_checks++;
        if (count !== 5'd16 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL fullrw_refill: count=%0d full=%b want 16 1", count, full);
        end
        test_drain("fullrw");
    endtask

    task automatic test_simul_rw();
        apply(4'b1111, pack4('h50, 'h51, 'h52, 'h53), 1'b0);
        tick();
        apply(4'b0001, pack4('h54, 0, 0, 0), 1'b0);
        tick();
        apply(4'b0100, pack4('h77, 'h77, 'h60, 'h77), 1'b1);
        n_checks++;
        if (data_out !== 21'h50) begin
            n_fail++;
            $display("FAIL simul_head: got 0x%0h want 0x50", data_out);
        end
        tick();
        n_checks++;
        if (count !== 5'd5) begin
            n_fail++;
            $display("FAIL simul_count: got %0d want 5", count);
        end
        n_checks++;
        if (sb.size() != 5 || sb[4] !== 21'h60) begin
            n_fail++;
            $display("FAIL simul_model: size=%0d tail=0x%0h want 5 0x60", sb.size(), sb[4]);
        end
        test_drain("simul");
    endtask

    task automatic test_underflow_wrap();
        apply('0, '0, 1'b1);
        tick();
        n_checks++;
        if (underflow !== 1'b1 || count !== 5'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_flag: unf=%b count=%0d empty=%b want 1 0 1", underflow, count, empty);
        end
        apply(4'b0001, pack4('h55, 0, 0, 0), 1'b0);
        tick();
        n_checks++;
        if (empty !== 1'b0 || data_out !== 21'h55) begin
            n_fail++;
            $display("FAIL underflow_ptr: empty=%b head=0x%0h want 0 0x55", empty, data_out);
        end
        test_drain("latency");
        for (int c = 0; c < 10; c++) begin
            apply(4'b0011, pack4('h100 + 2*c, 'h101 + 2*c, 0, 0), (mcount > 0));
            if (read_en) begin
                n_checks++;
                if (data_out !== sb[0]) begin
                    n_fail++;
                    $display("FAIL wrap_order: got 0x%0h want 0x%0h", data_out, sb[0]);
                end
            end
            tick();
        end
        n_checks++;
        if (count !== 5'd11) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d want 11", count);
        end
        test_drain("wrap");
    endtask

    task automatic test_reset_mid();
        apply(4'b1111, pack4('h80, 'h81, 'h82, 'h83), 1'b0);
        tick();
        apply(4'b1111, pack4('h84, 'h85, 'h86, 'h87), 1'b0);
        tick();
        apply(4'b0001, pack4('h88, 0, 0, 0), 1'b0);
        tick();
        n_checks++;
        if (count !== 5'd9 || overflow !== 1'b1 || underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: count=%0d ovf=%b unf=%b want 9 1 1", count, overflow, underflow);
        end
        apply(4'b1111, pack4('h90, 'h91, 'h92, 'h93), 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_post: count=%0d empty=%b ovf=%b unf=%b want 0 1 0 0", count, empty, overflow, underflow);
        end
        n_checks++;
        if (write_ready !== 4'b1111) begin
            n_fail++;
            $display("FAIL rstmid_ready: got %b want 1111", write_ready);
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_partial();
        test_full_read_write();
        test_simul_rw();
        test_underflow_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
